button_color_reader: RTL and testbench
======================================

BUTTON_COLOR_READER -- requirements
Module: button_color_reader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, is the number of stable cycles required to accept a level change (20 ms at 12 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 12000000, is the hold time in cycles that classifies a press as long (1 s at 12 MHz).
REQ-003 Port hw_clk: input, 1 bit, the single clock for the block.
REQ-004 Port hw_rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port btn_n: input, 1 bit, raw push-button level, active low and asynchronous to hw_clk.
REQ-006 Port color_select: output, 3 bits, current color code using the LED-driver encoding (000 R, 001 G, 010 B, 011 C, 100 Y, 101 M, 110 off, 111 W).
REQ-007 Port color_valid: output, 1 bit, one-cycle pulse in the cycle color_select takes a new value.
REQ-008 Port btn_pressed: output, 1 bit, debounced button level, 1 while pressed.
REQ-009 Port long_press: output, 1 bit, one-cycle pulse on long-press detection; tied to 0 when LONG_PRESS_EN is undefined.

Function
REQ-010 btn_n shall pass through a two-flop synchronizer before any other logic; the synchronized signal is called s_press, where s_press = 1 means pressed.
REQ-011 The FSM shall have exactly four states: IDLE, DB_PRESS, HELD, DB_RELEASE.
REQ-012 In IDLE, s_press = 1 shall move the FSM to DB_PRESS and clear the debounce counter.
REQ-013 In DB_PRESS, the counter shall increment while s_press = 1; s_press = 0 shall return the FSM to IDLE with no output activity.
REQ-014 In DB_PRESS, when the counter reaches DEBOUNCE_CYCLES-1 with s_press = 1, the FSM shall enter HELD and set btn_pressed to 1 on the next cycle.
REQ-015 In HELD, the hold counter shall increment every cycle and saturate at LONG_PRESS_CYCLES; s_press = 0 shall move the FSM to DB_RELEASE with the debounce counter cleared.
REQ-016 In DB_RELEASE, s_press = 1 shall return the FSM to HELD with the hold counter preserved; DEBOUNCE_CYCLES consecutive cycles of s_press = 0 shall move it to IDLE and clear btn_pressed.
REQ-017 Color advance shall be color_select + 1 modulo 8, wrapping 111 -> 000, with color_valid asserted in the same cycle as the update.
REQ-018 Total latency from a btn_n edge to btn_pressed change shall be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
REQ-019 Counter widths shall be $clog2 of the respective parameter + 1, and no counter shall overflow.
REQ-020 Glitches shorter than DEBOUNCE_CYCLES shall produce no change on any output.

Reset
REQ-021 Assertion of hw_rst_n = 0 shall immediately force state IDLE, all counters to 0, synchronizer flops to 0, color_select to 3'b110 (off), and color_valid, btn_pressed and long_press to 0.
REQ-022 Reset mid-press shall discard the press entirely; after deassertion, a still-held button shall be treated as a new press and fully debounced from IDLE.
REQ-023 Reset deassertion is assumed synchronized externally; the block shall not generate outputs in the first cycle after deassertion.

Configuration
REQ-024 Macro LONG_PRESS_EN undefined: color shall advance on the HELD entry cycle, the hold counter and long_press logic shall be absent, and long_press shall be tied to 0.
REQ-025 Macro LONG_PRESS_EN defined: color shall advance on the DB_RELEASE -> IDLE transition only if the hold count is below LONG_PRESS_CYCLES.
REQ-026 Macro LONG_PRESS_EN defined: when the hold count first reaches LONG_PRESS_CYCLES, the block shall pulse long_press once, set color_select to 110, and pulse color_valid; the subsequent release shall not advance the color.

Verification (sim with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=40)
REQ-027 Reset, then one clean 20-cycle press -> color_select 110 -> 111 with a single color_valid pulse and btn_pressed high for the debounced press interval.
REQ-028 Bounce stimulus of 3-cycle pulses, then a stable 20-cycle press -> exactly one color advance; the bounce pulses alone produce no output change.
REQ-029 Nine clean presses from reset -> sequence 111, 000, 001, ..., 110, 111, confirming the wrap-around.
REQ-030 With LONG_PRESS_EN defined: 60-cycle hold from color 010 -> one long_press pulse at hold count 40, color_select = 110, and no advance on release.
REQ-031 hw_rst_n asserted while HELD -> outputs go to their reset values in the same cycle; the held button after release of reset causes exactly one debounced press.
REQ-032 A 4-cycle release glitch during HELD -> btn_pressed stays 1 and no color_valid pulse occurs.

Source files
------------

// File: rtl/button_color_reader.sv
// button_color_reader: debounced push button stepping through LED color codes.
// Define LONG_PRESS_EN to advance on release and turn the LED off on a long hold.
module button_color_reader #(
  parameter int DEBOUNCE_CYCLES   = 240000,
  parameter int LONG_PRESS_CYCLES = 12000000
) (
  input  logic       hw_clk,
  input  logic       hw_rst_n,
  input  logic       btn_n,
  output logic [2:0] color_select,
  output logic       color_valid,
  output logic       btn_pressed,
  output logic       long_press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [2:0] color_q, color_d;
  logic valid_q, valid_d, pressed_q, pressed_d;
  logic s_press, press_entry, release_exit;
  // sync flops hold the inverted level so their reset value means released
  assign s_press = sync_q[1];
  assign press_entry = (state_q == DB_PRESS) && (state_d == HELD);
  assign release_exit = (state_q == DB_RELEASE) && (state_d == IDLE);
`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  logic [HW-1:0] hold_q, hold_d;
  logic lp_q, lp_d, adv;
  always_ff @(posedge hw_clk or negedge hw_rst_n)
    if (!hw_rst_n) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end
  always_comb
    hold_d = press_entry ? '0 :
             (state_q == HELD && hold_q != HW'(LONG_PRESS_CYCLES)) ? hold_q + HW'(1) : hold_q;
  assign long_press = lp_q;
`else
  assign long_press = 1'b0;
`endif
  always_ff @(posedge hw_clk or negedge hw_rst_n)
    if (!hw_rst_n) begin
      sync_q    <= 2'b00;
      state_q   <= IDLE;
      cnt_q     <= '0;
      color_q   <= 3'b110;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], ~btn_n};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (s_press) begin
        state_d = DB_PRESS;
        cnt_d   = '0;
      end
      DB_PRESS: if (!s_press) state_d = IDLE;
        else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) state_d = HELD;
        else cnt_d = cnt_q + DW'(1);
      HELD: if (!s_press) begin
        state_d = DB_RELEASE;
        cnt_d   = '0;
      end
      default: if (s_press) state_d = HELD;
        else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) state_d = IDLE;
        else cnt_d = cnt_q + DW'(1);
    endcase
  end
  always_comb begin
    pressed_d = press_entry ? 1'b1 : release_exit ? 1'b0 : pressed_q;
`ifdef LONG_PRESS_EN
    lp_d    = (state_q == HELD) && (hold_q == HW'(LONG_PRESS_CYCLES - 1));
    adv     = release_exit && (hold_q < HW'(LONG_PRESS_CYCLES));
    color_d = lp_d ? 3'b110 : adv ? color_q + 3'd1 : color_q;
    valid_d = lp_d | adv;
`else
    color_d = press_entry ? color_q + 3'd1 : color_q;
    valid_d = press_entry;
`endif
  end
  assign color_select = color_q;
  assign color_valid  = valid_q;
  assign btn_pressed  = pressed_q;
endmodule

// File: tb/tb_button_color_reader.sv
// tb_button_color_reader: directed and random button stimulus checked every cycle
// against a run-length model of the debounced button and color sequence.
module tb_button_color_reader;
  localparam int DB = 8, LP = 40;
  logic hw_clk = 1'b0, hw_rst_n = 1'b1, btn_n = 1'b1;
  logic [2:0] color_select;
  logic color_valid, btn_pressed, long_press;
  int checks = 0, passed = 0;
  bit m_s1, m_s2, m_deb, m_held, m_valid, m_lp;
  int ones, zeros, hold;
  logic [2:0] m_color;

  button_color_reader #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)) dut (
    .hw_clk(hw_clk), .hw_rst_n(hw_rst_n), .btn_n(btn_n),
    .color_select(color_select), .color_valid(color_valid),
    .btn_pressed(btn_pressed), .long_press(long_press)
  );

  always #5 hw_clk = ~hw_clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s @%0t observed=%0b expected=%0b", tag, $time, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".color_select"}, color_select, m_color);
    chk({tag, ".color_valid"}, {2'b0, color_valid}, {2'b0, m_valid});
    chk({tag, ".btn_pressed"}, {2'b0, btn_pressed}, {2'b0, m_deb});
    chk({tag, ".long_press"}, {2'b0, long_press}, {2'b0, m_lp});
  endtask

  task automatic model_reset();
    {m_s1, m_s2, m_deb, m_held, m_valid, m_lp} = '0;
    ones = 0; zeros = 0; hold = 0;
    m_color = 3'b110;
  endtask

  // Debounced level flips after DB+1 consecutive equal samples of the synchronized input
  task automatic model_edge(input bit press);
    bit s;
    s = m_s2; m_s2 = m_s1; m_s1 = press;
    ones  = s ? ones + 1 : 0;
    zeros = s ? 0 : zeros + 1;
    m_valid = 0; m_lp = 0;
    if (!m_deb) begin
      if (ones >= DB + 1) begin
        m_deb = 1; m_held = 1; hold = 0;
`ifndef LONG_PRESS_EN
        m_color = m_color + 3'd1; m_valid = 1;
`endif
      end
    end else begin
`ifdef LONG_PRESS_EN
      if (m_held) begin
        if (hold == LP - 1) begin m_lp = 1; m_color = 3'b110; m_valid = 1; end
        if (hold < LP) hold++;
      end
`endif
      if (zeros >= DB + 1) begin
        m_deb = 0;
`ifdef LONG_PRESS_EN
        if (hold < LP) begin m_color = m_color + 3'd1; m_valid = 1; end
`endif
      end
      m_held = s;
    end
  endtask

  task automatic step(input bit press, input string tag);
    btn_n = ~press;
    @(posedge hw_clk);
    model_edge(press);
    #1 chk_all(tag);
    @(negedge hw_clk);
  endtask

  task automatic run(input bit press, input int n, input string tag);
    repeat (n) step(press, tag);
  endtask

  task automatic do_reset(input string tag);
    #2 hw_rst_n = 1'b0;
    #1 model_reset();
    chk_all(tag);
    @(negedge hw_clk);
    hw_rst_n = 1'b1;
  endtask

  task automatic clean_press(input int n, input string tag);
    run(1, n, tag);
    run(0, 25, tag);
  endtask

  initial begin
    model_reset();
    @(negedge hw_clk);
    do_reset("reset");
    run(0, 5, "idle");
    clean_press(20, "clean");
    repeat (4) begin
      run(1, 3, "bounce");
      run(0, 3, "bounce");
    end
    run(0, 10, "bounce");
    clean_press(20, "after_bounce");
    do_reset("reset2");
    for (int i = 0; i < 9; i++) clean_press(20, "wrap");
    run(1, 30, "glitch");
    run(0, 4, "glitch");
    run(1, 20, "glitch");
    run(0, 25, "glitch");
    run(1, 22, "rst_held");
    do_reset("rst_held");
    run(1, 30, "rst_held");
    run(0, 25, "rst_held");
    do_reset("reset3");
    for (int i = 0; i < 4; i++) clean_press(20, "to_blue");
    run(1, 60, "long");
    run(0, 25, "long");
    for (int i = 0; i < 150; i++) begin
      run(1, $urandom_range(1, 24), "rand");
      run(0, $urandom_range(1, 24), "rand");
      if ($urandom_range(0, 19) == 0) do_reset("rand_reset");
    end
    run(0, 25, "tail");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
